// File: rtl/math_addsub_seq_pkg.sv
// rtl/math_addsub_seq_pkg.sv - state and opcode encodings shared by the serial add/sub unit
package math_addsub_seq_pkg;

   typedef enum logic [1:0] {
      MATH_S_IDLE = 2'd0,
      MATH_S_RUN  = 2'd1,
      MATH_S_DONE = 2'd2
   } math_state_t;

   localparam logic MATH_OP_ADD = 1'b0;
   localparam logic MATH_OP_SUB = 1'b1;

endpackage

// File: rtl/math_adder_chunk.sv
// rtl/math_adder_chunk.sv - CHUNK-bit ripple slice; also exposes the carry into its top bit
module math_adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      math_adder_fullAdder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[CHUNK];
   assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/math_adder_fullAdder.sv
// rtl/math_adder_fullAdder.sv - one-bit full adder cell
module math_adder_fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/math_addsub_seq.sv
// rtl/math_addsub_seq.sv - multi-cycle adder/subtractor, one CHUNK-bit slice per clock
module math_addsub_seq
   import math_addsub_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   math_state_t      state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa, opb, res, res_nx;
   logic             carry;
   logic [CHUNK-1:0] sl_sum;
   logic             sl_cout, sl_cmsb;
   logic             accept, last;

   math_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (opa[CHUNK-1:0]),
      .b    (opb[CHUNK-1:0]),
      .cin  (carry),
      .s    (sl_sum),
      .cout (sl_cout),
      .cmsb (sl_cmsb)
   );

   // New slice enters from the top so the result ends up LSB-aligned after NCH shifts
   assign res_nx = WIDTH'({sl_sum, res} >> CHUNK);
   assign busy   = (state == MATH_S_RUN);
   assign done   = (state == MATH_S_DONE);
   assign last   = busy && (cnt == LAST);
   assign accept = start && !busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MATH_S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         MATH_S_IDLE: if (start) state_nx = MATH_S_RUN;
         MATH_S_RUN:  if (cnt == LAST) state_nx = MATH_S_DONE;
         MATH_S_DONE: state_nx = start ? MATH_S_RUN : MATH_S_IDLE;
         default:     state_nx = MATH_S_IDLE;
      endcase
   end

   // Subtract is a + ~b + ~borrow, so the inversion happens once at capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         opa   <= a;
         opb   <= b ^ {WIDTH{op == MATH_OP_SUB}};
         res   <= '0;
         carry <= cin ^ (op != MATH_OP_ADD);
      end else if (busy) begin
         cnt   <= cnt + 1'b1;
         opa   <= opa >> CHUNK;
         opb   <= opb >> CHUNK;
         res   <= res_nx;
         carry <= sl_cout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b1;
      end else if (last) begin
         sum  <= res_nx;
         cout <= sl_cout;
         ovf  <= sl_cout ^ sl_cmsb;
         zero <= (res_nx == '0);
      end
   end

endmodule

// File: tb/tb_math_addsub_seq.sv
// tb/tb_math_addsub_seq.sv - randomized and directed bench for math_addsub_seq
module tb_math_addsub_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, op = 1'b0, cin = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        busy, done, cout, ovf, zero;
   logic [15:0] sum;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   math_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   localparam int NSW = 8;
   localparam int SW_W [NSW] = '{8, 8, 16, 16, 16, 32, 32, 32};
   localparam int SW_C [NSW] = '{1, 4, 1, 4, 16, 1, 4, 16};

   logic [NSW-1:0] sw_start = '0;
   logic           sw_op = 1'b0, sw_cin = 1'b0;
   logic [31:0]    sw_a = '0, sw_b = '0;
   logic [31:0]    sw_sum [NSW];
   logic [NSW-1:0] sw_busy, sw_done, sw_cout, sw_ovf, sw_zero;

   for (genvar g = 0; g < NSW; g++) begin : g_sw
      localparam int W = SW_W[g];
      localparam int C = SW_C[g];
      logic [W-1:0] s;
      math_addsub_seq #(.WIDTH(W), .CHUNK(C)) u (
         .clk(clk), .rst(rst), .start(sw_start[g]), .op(sw_op),
         .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .cin(sw_cin),
         .busy(sw_busy[g]), .done(sw_done[g]), .sum(s),
         .cout(sw_cout[g]), .ovf(sw_ovf[g]), .zero(sw_zero[g])
      );
      assign sw_sum[g] = 32'(s);
   end

   // Reference: plain integer arithmetic on unsigned and signed views of the operands
   function automatic void model(input int w, input logic o, input logic [31:0] x,
                                 input logic [31:0] y, input logic ci,
                                 output logic [31:0] s, output logic co, output logic ov);
      longint m    = (longint'(1) << w) - 1;
      longint half = longint'(1) << (w - 1);
      longint c1   = longint'(ci);
      longint ux   = longint'(x) & m;
      longint uy   = longint'(y) & m;
      longint sx   = (ux >= half) ? ux - (m + 1) : ux;
      longint sy   = (uy >= half) ? uy - (m + 1) : uy;
      longint r, sr;
      if (o == 1'b0) begin
         r  = ux + uy + c1;
         sr = sx + sy + c1;
         co = ((r >> w) & 1) != 0;
      end else begin
         r  = ux - uy - c1;
         sr = sx - sy - c1;
         co = (ux >= uy + c1);
      end
      s  = 32'(r & m);
      ov = (sr >= half) || (sr < -half);
   endfunction

   function automatic logic [31:0] pick(input int w);
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'((longint'(1) << w) - 1);
         2:       return 32'(longint'(1) << (w - 1));
         3:       return 32'((longint'(1) << (w - 1)) - 1);
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, output int lat);
      op = o; a = x; b = y; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, sum, cout, ovf, zero} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b, want 0 0 0000 0 0 1",
                  busy, done, sum, cout, ovf, zero);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct packed {
      logic o; logic [15:0] x; logic [15:0] y; logic ci;
      logic [15:0] s; logic co; logic ov; logic z;
   } vec_t;

   task automatic test_flags();
      vec_t v [4];
      int lat;
      v[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      v[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      v[2] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      v[3] = '{1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_op(v[i].o, v[i].x, v[i].y, v[i].ci, lat);
         n_checks++;
         if (lat !== 4) begin
            n_fail++;
            $display("FAIL flags_latency[%0d]: got %0d want 4", i, lat);
         end
         n_checks++;
         if ({sum, cout, ovf, zero} !== {v[i].s, v[i].co, v[i].ov, v[i].z}) begin
            n_fail++;
            $display("FAIL flags_result[%0d]: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                     i, sum, cout, ovf, zero, v[i].s, v[i].co, v[i].ov, v[i].z);
         end
      end
   endtask

   task automatic test_ignore_start();
      int dones = 0, lat = 0;
      logic [15:0] got = '0;
      op = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 2) begin
            a = 16'h0F0F; b = 16'h0101; op = 1'b1; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            dones++;
            lat = c;
            got = sum;
         end
      end
      n_checks++;
      if (dones !== 1 || lat !== 4) begin
         n_fail++;
         $display("FAIL ignore_start_done: got %0d dones at cycle %0d want 1 at 4", dones, lat);
      end
      n_checks++;
      if (got !== 16'h2345) begin
         n_fail++;
         $display("FAIL ignore_start_sum: got %h want 2345", got);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, lat);
      n_checks++;
      if (lat !== 4 || sum !== 16'h0100) begin
         n_fail++;
         $display("FAIL b2b_first: got lat=%0d sum=%h want 4 0100", lat, sum);
      end
      op = 1'b1; a = 16'h1000; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
      end
      lat = 0;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== 4 || sum !== 16'h0FFF || cout !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: got lat=%0d sum=%h cout=%b want 4 0fff 1", lat, sum, cout);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0, lat;
      op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, sum, cout, ovf, zero} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b, want 0 0 0000 0 0 1",
                  busy, done, sum, cout, ovf, zero);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL reset_no_done: got %0d dones want 0", dones);
      end
      run_op(1'b0, 16'h1111, 16'h2222, 1'b0, lat);
      n_checks++;
      if (lat !== 4 || sum !== 16'h3333 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_recover: got lat=%0d sum=%h zero=%b want 4 3333 0", lat, sum, zero);
      end
   endtask

   task automatic test_random(input int n);
      logic [31:0] es;
      logic eco, eov;
      logic [15:0] x, y;
      logic o, ci;
      int lat;
      for (int k = 0; k < n; k++) begin
         x = 16'(pick(16)); y = 16'(pick(16));
         o = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
         model(16, o, {16'h0, x}, {16'h0, y}, ci, es, eco, eov);
         run_op(o, x, y, ci, lat);
         n_checks++;
         if (lat !== 4 || sum !== es[15:0] || cout !== eco || ovf !== eov || zero !== (es == 0)) begin
            n_fail++;
            $display("FAIL random16[%0d] op=%b a=%h b=%h cin=%b: got lat=%0d sum=%h c=%b v=%b z=%b want 4 %h %b %b %b",
                     k, o, x, y, ci, lat, sum, cout, ovf, zero, es[15:0], eco, eov, es == 0);
         end
      end
   endtask

   task automatic test_sweep(input int i, input int n);
      int w = SW_W[i];
      int nch = SW_W[i] / SW_C[i];
      logic [31:0] es;
      logic eco, eov;
      int lat;
      for (int k = 0; k < n; k++) begin
         sw_a = pick(w); sw_b = pick(w);
         sw_op = 1'($urandom_range(0, 1)); sw_cin = 1'($urandom_range(0, 1));
         model(w, sw_op, sw_a, sw_b, sw_cin, es, eco, eov);
         sw_start[i] = 1'b1;
         @(posedge clk); #1;
         sw_start[i] = 1'b0;
         lat = 0;
         while (!sw_done[i] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
         end
         n_checks++;
         if (lat !== nch || sw_busy[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_latency W=%0d C=%0d: got %0d busy=%b want %0d busy=0",
                     w, SW_C[i], lat, sw_busy[i], nch);
         end
         n_checks++;
         if (sw_sum[i] !== es || sw_cout[i] !== eco || sw_ovf[i] !== eov || sw_zero[i] !== (es == 0)) begin
            n_fail++;
            $display("FAIL sweep_result W=%0d C=%0d op=%b a=%h b=%h cin=%b: got %h c=%b v=%b z=%b want %h %b %b %b",
                     w, SW_C[i], sw_op, sw_a, sw_b, sw_cin, sw_sum[i], sw_cout[i], sw_ovf[i], sw_zero[i],
                     es, eco, eov, es == 0);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_flags();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random(40);
      for (int i = 0; i < NSW; i++) test_sweep(i, 200);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
